// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and state type for the LCD value formatter.
//   LINE_LENGTH_DEFAULT : default characters per LCD line
//   ASCII_SPACE/ZERO/MINUS : character codes used when building lines
//   fmt_state_t : formatter control states
package lcd_pkg;

  localparam int unsigned LINE_LENGTH_DEFAULT = 16;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_FORMAT,
    ST_SEND,
    ST_WAIT_DONE
  } fmt_state_t;

endpackage

// File: rtl/lcd_bin2bcd_seq.sv
// lcd_bin2bcd_seq: iterative shift-add-3 binary to BCD converter.
//   CLK, RESET : clock, asynchronous active-high reset
//   start      : load bin and begin conversion (takes priority over a running one)
//   bin        : binary input, sampled on start
//   done       : one-cycle pulse, bcd is final from this cycle on
//   bcd        : DIGITS packed BCD digits, least significant digit in [3:0]
// One shift per cycle, VALUE_WIDTH shifts in total after the load.
module lcd_bin2bcd_seq #(
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned DIGITS      = 5
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] bin,
  output logic                   done,
  output logic [4*DIGITS-1:0]    bcd
);

  localparam int unsigned CW = $clog2(VALUE_WIDTH + 1);

  logic [VALUE_WIDTH-1:0] sh;
  logic [CW-1:0]          cnt;
  logic                   run;
  logic [4*DIGITS-1:0]    adj;

  // Every digit >= 5 gets +3 so the following shift carries correctly.
  always_comb begin
    adj = bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh   <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh  <= bin;
        bcd <= '0;
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt       <= cnt + 1'b1;
        if (cnt == CW'(VALUE_WIDTH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_value_formatter.sv
// lcd_value_formatter: converts a strobed binary value to decimal and feeds
// the LCD controller with a static label line and a right-justified number.
//   CLK, RESET  : clock, asynchronous active-high reset
//   value       : binary value to display, sampled when value_valid is high
//   value_valid : one-cycle strobe
//   sendingDone : controller completion, only its rising edge is used
//   line1       : static label, character 0 in the top byte
//   line2       : right-justified number, leading positions filled with spaces
//   sendText    : one-cycle request to the controller
//   busy        : high whenever the control state is not idle
// Build option: define LCD_FMT_SIGNED_EN to treat value as two's complement
// and show a leading '-' for negative values.
// LINE_LENGTH must exceed DIGITS so a minus sign always fits.
module lcd_value_formatter
  import lcd_pkg::*;
#(
  parameter int unsigned LINE_LENGTH = LINE_LENGTH_DEFAULT,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned DIGITS      = 5,
  parameter logic [8*LINE_LENGTH-1:0] LABEL =
    {"Value:", {(LINE_LENGTH-6){ASCII_SPACE}}}
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   value_valid,
  input  logic                   sendingDone,
  output logic [8*LINE_LENGTH:1] line1,
  output logic [8*LINE_LENGTH:1] line2,
  output logic                   sendText,
  output logic                   busy
);

  fmt_state_t             state;
  logic                   pending;
  logic [VALUE_WIDTH-1:0] pend_val;
  logic                   done_q;

  logic                   start;
  logic [VALUE_WIDTH-1:0] raw_sel;
  logic [VALUE_WIDTH-1:0] cvt_in;
  logic                   cvt_done;
  logic [4*DIGITS-1:0]    bcd;

  logic [8*LINE_LENGTH-1:0] line_next;
  logic [3:0]               digit;
  logic                     lead;

`ifdef LCD_FMT_SIGNED_EN
  logic                 neg_in;
  logic                 neg_q;
  logic [VALUE_WIDTH:0] ext;
  logic [VALUE_WIDTH:0] mag;
  int unsigned          ndig;
`endif

  // A fresh strobe in idle beats any pending value.
  assign raw_sel = value_valid ? value : pend_val;
  assign start   = (state == ST_IDLE) && (value_valid || pending);

`ifdef LCD_FMT_SIGNED_EN
  // Magnitude is formed one bit wider so the most negative value negates cleanly.
  assign neg_in = raw_sel[VALUE_WIDTH-1];
  assign ext    = {raw_sel[VALUE_WIDTH-1], raw_sel};
  assign mag    = neg_in ? (~ext + 1'b1) : ext;
  assign cvt_in = mag[VALUE_WIDTH-1:0];
`else
  assign cvt_in = raw_sel;
`endif

  lcd_bin2bcd_seq #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .DIGITS      (DIGITS)
  ) u_bin2bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .bin   (cvt_in),
    .done  (cvt_done),
    .bcd   (bcd)
  );

  // Scan digits from most significant; blanking stops at the first non-zero
  // digit, and the units digit is always shown. Digit i lands at character
  // LINE_LENGTH-1-i, which is byte i counted from the bottom of the line.
  always_comb begin
    line_next = {LINE_LENGTH{ASCII_SPACE}};
    digit     = '0;
    lead      = 1'b1;
`ifdef LCD_FMT_SIGNED_EN
    ndig      = 0;
`endif
    for (int unsigned k = 0; k < DIGITS; k++) begin
      digit = bcd[4*(DIGITS-1-k) +: 4];
      if (digit != 4'd0 || k == DIGITS - 1)
        lead = 1'b0;
      if (!lead) begin
        line_next[8*(DIGITS-1-k) +: 8] = ASCII_ZERO + {4'd0, digit};
`ifdef LCD_FMT_SIGNED_EN
        ndig = ndig + 1;
`endif
      end
    end
`ifdef LCD_FMT_SIGNED_EN
    if (neg_q)
      line_next[8*ndig +: 8] = ASCII_MINUS;
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      pend_val <= '0;
      done_q   <= 1'b0;
      line1    <= LABEL;
      line2    <= {LINE_LENGTH{ASCII_SPACE}};
      sendText <= 1'b0;
      busy     <= 1'b0;
`ifdef LCD_FMT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      done_q   <= sendingDone;
      sendText <= 1'b0;

      // Strobes outside idle coalesce; the newest value overwrites.
      if (state != ST_IDLE && value_valid) begin
        pending  <= 1'b1;
        pend_val <= value;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_CONVERT;
`ifdef LCD_FMT_SIGNED_EN
            neg_q   <= neg_in;
`endif
          end
        end
        ST_CONVERT: begin
          if (cvt_done)
            state <= ST_FORMAT;
        end
        ST_FORMAT: begin
          line2    <= line_next;
          sendText <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (sendingDone && !done_q) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
